// File: rtl/ysyx_23060072_if_stage_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch stage.
package ysyx_23060072_if_stage_pkg;

    localparam logic [31:0] IF_RESET_PC_DEF  = 32'h8000_0000;
    localparam logic [31:0] IF_NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [2:0] {
        IF_IDLE  = 3'd0,
        IF_REQ   = 3'd1,
        IF_RESP  = 3'd2,
        IF_BLOCK = 3'd3,
        IF_DROP  = 3'd4
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ysyx_23060072_if_skid.sv
// One-entry {pc, instr} holding buffer used while the IF/ID register is stalled.
module ysyx_23060072_if_skid
    import ysyx_23060072_if_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clear_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  if_entry_t data_i,
    output if_entry_t data_o,
    output logic      valid_o
);

    if_entry_t data_q;
    logic      valid_q;

    // Occupancy: clear beats push, push beats pop (push+pop keeps it full with new data).
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (push_i) begin
            valid_q <= 1'b1;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    // Payload capture on push.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= {32'h0000_0000, 32'h0000_0000};
        end else if (push_i && !clear_i) begin
            data_q <= data_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ysyx_23060072_if_stage.sv
// Instruction fetch stage: fetch PC, single-outstanding imem requests,
// redirect handling with stale-response dropping, and the IF/ID register.
module ysyx_23060072_if_stage
    import ysyx_23060072_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_hold_flag_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        timer_interrupt_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] pc_o,
    output logic        timer_interrupt_o
);

    if_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;     // address of the pending/outstanding request
    logic [31:0] tgt_q, tgt_d;       // redirect target used when leaving DROP
    logic        req_q, req_d;
    logic        drop_q, drop_d;     // redirect seen while a request waits for gnt
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        tmr_q, tmr_d;

    logic [31:0] jump_tgt_s;
    logic        rsp_s, take_s, push_s, pop_s, direct_s, skid_valid_s;
    if_entry_t   skid_in_s, skid_out_s;

    assign jump_tgt_s = align_word(jump_addr_i);
    assign rsp_s      = (state_q == IF_RESP) && imem_rvalid_i;
    assign take_s     = rsp_s && !jump_flag_i;
    assign pop_s      = !jump_flag_i && !if_hold_flag_i && skid_valid_s;
    assign push_s     = take_s && (if_hold_flag_i || skid_valid_s);
    assign direct_s   = take_s && !if_hold_flag_i && !skid_valid_s;
    assign skid_in_s  = '{pc: addr_q, instr: imem_rdata_i};

    ysyx_23060072_if_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear_i (jump_flag_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (skid_in_s),
        .data_o  (skid_out_s),
        .valid_o (skid_valid_s)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IF_IDLE;
            addr_q  <= RESET_PC;
            tgt_q   <= RESET_PC;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0000_0000;
            tmr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            tmr_q   <= tmr_d;
        end
    end

    // Next fetch state; a buffered response that cannot drain parks the FSM in BLOCK.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IF_IDLE: begin
                state_d = IF_REQ;
            end
            IF_REQ: begin
                if (imem_gnt_i) begin
                    state_d = (jump_flag_i || drop_q) ? IF_DROP : IF_RESP;
                end else begin
                    state_d = IF_REQ;
                end
            end
            IF_RESP: begin
                if (imem_rvalid_i) begin
                    if (jump_flag_i) begin
                        state_d = IF_REQ;
                    end else if (push_s) begin
                        state_d = IF_BLOCK;
                    end else begin
                        state_d = IF_REQ;
                    end
                end else if (jump_flag_i) begin
                    state_d = IF_DROP;
                end else begin
                    state_d = IF_RESP;
                end
            end
            IF_BLOCK: begin
                if (jump_flag_i || !skid_valid_s || pop_s) begin
                    state_d = IF_REQ;
                end else begin
                    state_d = IF_BLOCK;
                end
            end
            IF_DROP: begin
                if (imem_rvalid_i) begin
                    state_d = IF_REQ;
                end else begin
                    state_d = IF_DROP;
                end
            end
            default: begin
                state_d = IF_IDLE;
            end
        endcase
    end

    // Request address, redirect target and drop flag for the next cycle.
    always_comb begin
        addr_d = addr_q;
        drop_d = drop_q;
        req_d  = (state_d == IF_REQ);
        if (jump_flag_i) begin
            tgt_d = jump_tgt_s;
        end else begin
            tgt_d = tgt_q;
        end
        case (state_q)
            IF_IDLE, IF_BLOCK: begin
                if (jump_flag_i) begin
                    addr_d = jump_tgt_s;
                end else begin
                    addr_d = addr_q;
                end
            end
            IF_REQ: begin
                if (imem_gnt_i) begin
                    drop_d = 1'b0;
                end else if (jump_flag_i) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            IF_RESP: begin
                if (imem_rvalid_i) begin
                    addr_d = jump_flag_i ? jump_tgt_s : (addr_q + 32'd4);
                end else begin
                    addr_d = addr_q;
                end
            end
            IF_DROP: begin
                if (imem_rvalid_i) begin
                    addr_d = jump_flag_i ? jump_tgt_s : tgt_q;
                end else begin
                    addr_d = addr_q;
                end
            end
            default: begin
                addr_d = addr_q;
            end
        endcase
    end

    // IF/ID load: redirect bubble, hold, skid drain, direct response, else bubble.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        tmr_d   = tmr_q;
        if (jump_flag_i) begin
            instr_d = NOP_INSTR;
            tmr_d   = 1'b0;
        end else if (if_hold_flag_i) begin
            instr_d = instr_q;
        end else if (skid_valid_s) begin
            instr_d = skid_out_s.instr;
            pc_d    = skid_out_s.pc;
            tmr_d   = timer_interrupt_i;
        end else if (direct_s) begin
            instr_d = imem_rdata_i;
            pc_d    = addr_q;
            tmr_d   = timer_interrupt_i;
        end else begin
            instr_d = NOP_INSTR;
            tmr_d   = 1'b0;
        end
    end

    assign imem_req_o        = req_q;
    assign imem_addr_o       = addr_q;
    assign instr_rdata_o     = instr_q;
    assign pc_o              = pc_q;
    assign timer_interrupt_o = tmr_q;

endmodule

// File: tb/tb_ysyx_23060072_if_stage.sv
// Bench for the fetch stage: cycle table, two corner sequences, and a
// randomized run checked against an in-order program-stream model.
module tb_ysyx_23060072_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, hold, jump, tmr_i;
    logic [31:0] jaddr;
    logic        req, gnt, rvalid, tmr_o;
    logic [31:0] addr, rdata, instr_o, pc_o;

    int n_chk  = 0;
    int n_fail = 0;

    // memory model controls/state
    bit          rnd_mem = 1'b0;
    int          gnt_dly = 0;
    int          rv_dly  = 0;
    int          cur_dly = 0;
    int          wait_cnt = 0;
    int          rv_cnt  = 0;
    bit          pend    = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    typedef struct {
        logic        rst, hold, jump;
        logic [31:0] jaddr;
        logic        tmr;
        logic        e_req;
        logic [31:0] e_addr, e_instr, e_pc;
        logic        e_tmr;
    } vec_t;
    vec_t vecs [14];

    // random-phase model state
    logic [31:0] exp_pc, p_instr, p_pc, p_addr, tgt;
    logic        p_tmr, p_req, e_rst, e_hold, e_jump, e_tmr;
    int          delivered;
    bit          found;

    always #5 clk = ~clk;

    ysyx_23060072_if_stage dut (
        .clk               (clk),
        .rst               (rst),
        .if_hold_flag_i    (hold),
        .jump_flag_i       (jump),
        .jump_addr_i       (jaddr),
        .timer_interrupt_i (tmr_i),
        .imem_req_o        (req),
        .imem_addr_o       (addr),
        .imem_gnt_i        (gnt),
        .imem_rvalid_i     (rvalid),
        .imem_rdata_i      (rdata),
        .instr_rdata_o     (instr_o),
        .pc_o              (pc_o),
        .timer_interrupt_o (tmr_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        else if (a == 32'h8000_0004) return 32'h0020_8133;
        else return a ^ 32'h5A5A_5A58;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; hold = 1'b0; jump = 1'b0; jaddr = 32'h0; tmr_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   {31'h0, req},   32'h0);
        chk({tag, "_addr"},  addr,           RPC);
        chk({tag, "_instr"}, instr_o,        NOP);
        chk({tag, "_pc"},    pc_o,           32'h0);
        chk({tag, "_tmr"},   {31'h0, tmr_o}, 32'h0);
    endtask

    // Instruction memory: gnt after a per-request delay, rvalid after a further delay.
    initial begin
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            gnt = 1'b0;
            rvalid = 1'b0;
            if (rst) begin
                pend = 1'b0;
                wait_cnt = 0;
            end else begin
                if (pend) begin
                    if (rv_cnt == 0) begin
                        rvalid = 1'b1;
                        rdata = mem_word(pend_addr);
                        pend = 1'b0;
                    end else begin
                        rv_cnt--;
                    end
                end
                if (req && !pend) begin
                    if (wait_cnt == 0) cur_dly = rnd_mem ? int'($urandom_range(0, 3)) : gnt_dly;
                    if (wait_cnt >= cur_dly) begin
                        gnt = 1'b1;
                        pend = 1'b1;
                        pend_addr = addr;
                        rv_cnt = rnd_mem ? int'($urandom_range(0, 2)) : rv_dly;
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst hold jump jaddr tmr | req addr instr pc tmr
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8000_0000, NOP, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0000, NOP, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8000_0000, NOP, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0004, 32'h0010_0093, 32'h8000_0000, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0004, NOP, 32'h8000_0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8000_0008, NOP, 32'h8000_0000, 1'b0};
        vecs[6]  = vecs[5];
        vecs[7]  = vecs[5];
        vecs[8]  = vecs[5];
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0008, 32'h0020_8133, 32'h8000_0004, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8000_0008, NOP, 32'h8000_0004, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h8000_0103, 1'b1, 1'b1, 32'h8000_0100, NOP, 32'h8000_0004, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8000_0100, NOP, 32'h8000_0004, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0104, 32'hDA5A_5B58, 32'h8000_0100, 1'b0};

        // cycle table with a zero-wait memory
        for (int i = 0; i < 14; i++) begin
            rst = vecs[i].rst; hold = vecs[i].hold; jump = vecs[i].jump;
            jaddr = vecs[i].jaddr; tmr_i = vecs[i].tmr;
            tick();
            chk($sformatf("tbl%0d_req", i),   {31'h0, req},   {31'h0, vecs[i].e_req});
            chk($sformatf("tbl%0d_addr", i),  addr,           vecs[i].e_addr);
            chk($sformatf("tbl%0d_instr", i), instr_o,        vecs[i].e_instr);
            chk($sformatf("tbl%0d_pc", i),    pc_o,           vecs[i].e_pc);
            chk($sformatf("tbl%0d_tmr", i),   {31'h0, tmr_o}, {31'h0, vecs[i].e_tmr});
        end

        // redirect while the request waits 3 cycles for gnt
        gnt_dly = 3;
        do_reset();
        tick();
        chk("gd_req1", {31'h0, req}, 32'h1);
        chk("gd_addr1", addr, RPC);
        jump = 1'b1; jaddr = 32'h8000_0200;
        tick();
        jump = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("gd_stable_req%0d", k), {31'h0, req}, 32'h1);
            chk($sformatf("gd_stable_addr%0d", k), addr, RPC);
            tick();
        end
        chk("gd_drop_req", {31'h0, req}, 32'h0);
        tick();
        chk("gd_tgt_req", {31'h0, req}, 32'h1);
        chk("gd_tgt_addr", addr, 32'h8000_0200);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (instr_o !== NOP) found = 1'b1;
        end
        chk("gd_found", {31'h0, found}, 32'h1);
        chk("gd_instr", instr_o, mem_word(32'h8000_0200));
        chk("gd_pc", pc_o, 32'h8000_0200);

        // PC wrap at the top of the address space
        gnt_dly = 0;
        do_reset();
        jump = 1'b1; jaddr = 32'hFFFF_FFFE;
        tick();
        jump = 1'b0;
        chk("wr_addr", addr, 32'hFFFF_FFFC);
        tick(); tick();
        chk("wr_instr", instr_o, mem_word(32'hFFFF_FFFC));
        chk("wr_pc", pc_o, 32'hFFFF_FFFC);
        chk("wr_next_addr", addr, 32'h0000_0000);
        tick(); tick();
        chk("wr_instr0", instr_o, mem_word(32'h0000_0000));
        chk("wr_pc0", pc_o, 32'h0000_0000);

        // randomized run against the program-order model
        rnd_mem = 1'b1;
        do_reset();
        chk_reset("rnd_rst0");
        exp_pc = RPC;
        delivered = 0;
        for (int c = 0; c < 4000; c++) begin
            p_instr = instr_o; p_pc = pc_o; p_tmr = tmr_o; p_req = req; p_addr = addr;
            e_rst  = ($urandom_range(0, 499) == 0);
            e_hold = ($urandom_range(0, 99) < 30);
            e_jump = !e_rst && ($urandom_range(0, 99) < 4);
            e_tmr  = 1'($urandom_range(0, 1));
            tgt = $urandom();
            if ($urandom_range(0, 1) == 1) tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000F);
            rst = e_rst; hold = e_hold; jump = e_jump; jaddr = tgt; tmr_i = e_tmr;
            tick();
            if (e_rst) begin
                chk_reset("rnd_rst");
                exp_pc = RPC;
            end else begin
                if (p_req && !gnt) begin
                    chk("rnd_req_held", {31'h0, req}, 32'h1);
                    chk("rnd_addr_held", addr, p_addr);
                end
                if (e_jump) begin
                    chk("rnd_jmp_instr", instr_o, NOP);
                    chk("rnd_jmp_tmr", {31'h0, tmr_o}, 32'h0);
                    exp_pc = tgt & 32'hFFFF_FFFC;
                end else if (e_hold) begin
                    chk("rnd_hold_instr", instr_o, p_instr);
                    chk("rnd_hold_pc", pc_o, p_pc);
                    chk("rnd_hold_tmr", {31'h0, tmr_o}, {31'h0, p_tmr});
                end else if (instr_o === NOP) begin
                    chk("rnd_nop_pc", pc_o, p_pc);
                    chk("rnd_nop_tmr", {31'h0, tmr_o}, 32'h0);
                end else begin
                    chk("rnd_pc", pc_o, exp_pc);
                    chk("rnd_instr", instr_o, mem_word(exp_pc));
                    chk("rnd_tmr", {31'h0, tmr_o}, {31'h0, e_tmr});
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                end
            end
        end
        rst = 1'b0; hold = 1'b0; jump = 1'b0;
        chk("rnd_progress", {31'h0, (delivered >= 100)}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
